// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a small prefetch queue in front of decode.
// Issues in-order requests to a variable-latency instruction memory, pairs each response
// with its own fetch address, and drops stale responses after a branch redirect.
// Optional feature: define IF_BYPASS_EN to forward a response straight to the outputs
// when the queue is empty (saves one cycle of fetch latency).
module if_prefetch_stage #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid_out
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [AW-1:0] tag_head_q, tag_head_d, tag_tail_q, tag_tail_d;

    logic [31:0] q_addr_q [DEPTH];
    logic [31:0] q_word_q [DEPTH];
    // Address+4 of each outstanding request, in issue order
    logic [31:0] tag_q [DEPTH];

    logic [CW:0] occupancy;
    logic        accept, keep, bypass, push, pop;
    logic [31:0] rsp_tag;

    // Next-state, request admission and output selection
    always_comb begin
        occupancy = {1'b0, count_q} + {1'b0, inflight_q};
        // Admission counts in-flight requests so a later push can never overflow the queue
        imem_req  = !rst && !branch_taken && (occupancy < DEPTH_OCC);
        imem_addr = fetch_pc_q;
        accept    = imem_req && imem_ready;
        rsp_tag   = tag_q[tag_head_q];
        keep      = imem_rvalid && (discard_q == '0) && !branch_taken;
`ifdef IF_BYPASS_EN
        bypass    = keep && (count_q == '0);
`else
        bypass    = 1'b0;
`endif
        // A bypassed word is consumed directly unless decode is frozen
        push      = keep && !(bypass && !freeze);
        pop       = (count_q != '0) && !freeze && !branch_taken;

        fetch_pc_d = fetch_pc_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        q_head_d   = q_head_q + AW'(pop);
        q_tail_d   = q_tail_q + AW'(push);
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rvalid);
        tag_head_d = tag_head_q + AW'(imem_rvalid);
        tag_tail_d = tag_tail_q + AW'(accept);
        discard_d  = discard_q;
        if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // Redirect wins over everything: every request outstanding after this edge is stale
        if (branch_taken) begin
            fetch_pc_d = branch_address;
            count_d    = '0;
            q_head_d   = '0;
            q_tail_d   = '0;
            discard_d  = inflight_q - CW'(imem_rvalid);
        end

        valid_out   = 1'b0;
        pc_out      = 32'h0;
        instruction = 32'h0;
        if (bypass) begin
            valid_out   = 1'b1;
            pc_out      = rsp_tag;
            instruction = imem_rdata;
        end else if (count_q != '0) begin
            valid_out   = 1'b1;
            pc_out      = q_addr_q[q_head_q];
            instruction = q_word_q[q_head_q];
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= PC_RESET;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            tag_head_q <= '0;
            tag_tail_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            tag_head_q <= tag_head_d;
            tag_tail_q <= tag_tail_d;
        end
    end

    // Queue and tag storage; contents are qualified by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr_q[q_tail_q] <= rsp_tag;
            q_word_q[q_tail_q] <= imem_rdata;
        end
        if (accept) begin
            tag_q[tag_tail_q] <= fetch_pc_q + 32'd4;
        end
    end

    // A response with nothing outstanding is a memory protocol violation
    a_rvalid_has_request: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid |-> (inflight_q != '0));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized bench for if_prefetch_stage: a behavioural memory, a scoreboard of expected
// {pc+4, word} pairs fed at request acceptance, and an independent monitor that pops on
// every consumed instruction.
module tb_if_prefetch_stage;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] PC_RESET = 32'h0;
`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        valid_out;

    if_prefetch_stage #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instruction(instruction), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    exp_t exp_q[$];
    req_t mem_q[$];

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int cycle  = 0;

    // Stimulus knobs
    int freeze_pct = 0, branch_pct = 0, ready_pct = 100, lat_min = 1, lat_max = 1;
    bit ovr_freeze_en = 0, ovr_freeze = 0, ovr_branch = 0;
    logic [31:0] ovr_addr = 32'h0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Driver: control inputs plus an in-order, variable-latency memory
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                mem_q.delete();
                freeze = 0; branch_taken = 0; imem_ready = 0; imem_rvalid = 0;
                continue;
            end
            freeze = ovr_freeze_en ? ovr_freeze : ($urandom_range(99) < freeze_pct);
            if (ovr_branch) begin
                branch_taken   = 1'b1;
                branch_address = ovr_addr;
                ovr_branch     = 1'b0;
            end else begin
                branch_taken   = ($urandom_range(99) < branch_pct);
                branch_address = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0
                                                          : ($urandom() & 32'hFFFF_FFFC);
            end
            imem_ready = ($urandom_range(99) < ready_pct);
            if (mem_q.size() != 0 && mem_q[0].due <= cycle) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memfn(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom();
            end
            #1;
            if (branch_taken) begin
                exp_q.delete();
                check("no_req_on_branch", {31'b0, imem_req}, 32'd0);
            end
            if (imem_req && imem_ready) begin
                req_t r;
                exp_t e;
                r.addr = imem_addr;
                r.due  = cycle + int'($urandom_range(lat_max, lat_min));
                mem_q.push_back(r);
                e.pc   = imem_addr + 32'd4;
                e.word = memfn(imem_addr);
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compares every consumed instruction against the scoreboard
    initial begin
        logic [31:0] prev_pc, prev_ins;
        bit prev_hold;
        prev_hold = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_hold = 0;
                continue;
            end
            if (!valid_out) begin
                check("empty_zero", pc_out | instruction, 32'h0);
            end
            if (prev_hold) begin
                check("freeze_valid", {31'b0, valid_out}, 32'd1);
                check("freeze_pc", pc_out, prev_pc);
                check("freeze_ins", instruction, prev_ins);
            end
            if (valid_out && !freeze && !branch_taken) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", pc_out, 32'hDEAD_DEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pop_pc", pc_out, e.pc);
                    check("pop_ins", instruction, e.word);
                    pops++;
                end
            end
            prev_hold = valid_out && freeze && !branch_taken;
            prev_pc   = pc_out;
            prev_ins  = instruction;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #3;
    endtask

    initial begin
        bit seen;
        rst = 1; freeze = 0; branch_taken = 0; branch_address = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        #3;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, PC_RESET);
        check("rst_pc", pc_out, 32'h0);
        check("rst_ins", instruction, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        repeat (2) sync();
        rst = 0;

        // First response: bypass presents it immediately, otherwise one cycle later
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample();
            if (imem_rvalid) seen = 1;
        end
        check("first_rvalid_seen", {31'b0, seen}, 32'd1);
        check("first_rvalid_valid", {31'b0, valid_out}, {31'b0, BYP});
        sample();
        check("after_rvalid_valid", {31'b0, valid_out}, 32'd1);
        repeat (15) sample();

        // Freeze: fetch fills queue + in-flight to DEPTH, then stops requesting
        sync();
        ovr_freeze_en = 1; ovr_freeze = 1;
        repeat (10) sample();
        check("freeze_req", {31'b0, imem_req}, 32'd0);
        check("freeze_backlog", exp_q.size(), DEPTH);
        check("freeze_has_head", {31'b0, valid_out}, 32'd1);
        sync();
        ovr_freeze_en = 0;
        repeat (20) sample();

        // Latency 3 then redirect to 0x100; stale responses must be dropped
        lat_min = 3; lat_max = 3;
        repeat (10) sample();
        sync();
        ovr_addr = 32'h100; ovr_branch = 1;
        sample();
        check("branch_seen", {31'b0, branch_taken}, 32'd1);
        sample();
        check("post_branch_empty", {31'b0, valid_out}, 32'd0);
        repeat (20) sample();

        // Address wrap at the top of the address space
        lat_min = 1; lat_max = 1;
        repeat (5) sample();
        sync();
        ovr_addr = 32'hFFFF_FFFC; ovr_branch = 1;
        sample();
        sample();
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_req", {31'b0, imem_req}, 32'd1);
        sample();
        check("wrap_next_addr", imem_addr, 32'h0);
        repeat (10) sample();

        // Random traffic: variable latency, back-pressure, freezes and branches
        lat_min = 1; lat_max = 4; ready_pct = 70; freeze_pct = 30; branch_pct = 5;
        repeat (3000) sample();

        // Quiet period: backlog stays bounded and instructions keep flowing
        freeze_pct = 0; branch_pct = 0; ready_pct = 100;
        repeat (50) sample();
        checks++;
        if (exp_q.size() > DEPTH) begin
            errors++;
            $display("FAIL backlog_bound: got %0d expected <= %0d", exp_q.size(), DEPTH);
        end
        checks++;
        if (pops < 500) begin
            errors++;
            $display("FAIL progress: got %0d pops expected >= 500", pops);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
